// File: rtl/seq_sreg_8b_deserializer_if.sv
// ---------------------------------------------------------------------------
// seq_sreg_8b_deserializer_if
// Bundles the serial line, the bit strobe and the byte-wide val/rdy output
// of the 8-bit framed deserializer.
//   en        : bit strobe, line sampled only when high
//   sin       : serial line (idle 0)
//   out_rdy   : consumer ready
//   out       : received byte (buffer contents)
//   out_val   : buffer holds a valid byte
//   frame_err : one-cycle pulse, stop bit was 1
//   overrun   : one-cycle pulse, good frame dropped because buffer full
// master = line driver / consumer side, slave = deserializer side.
// ---------------------------------------------------------------------------
interface seq_sreg_8b_deserializer_if;
    logic       en;
    logic       sin;
    logic       out_rdy;
    logic [7:0] out;
    logic       out_val;
    logic       frame_err;
    logic       overrun;

    modport master (
        output en, sin, out_rdy,
        input  out, out_val, frame_err, overrun
    );

    modport slave (
        input  en, sin, out_rdy,
        output out, out_val, frame_err, overrun
    );
endinterface

// File: rtl/seq_sreg_8b_deserializer.sv
// ---------------------------------------------------------------------------
// seq_sreg_8b_deserializer
// Framed serial-in / parallel-out receiver. Frame: start bit 1, data bits
// d7..d0 (MSB first), stop bit 0, one bit per enabled cycle. A good frame is
// written into a one-entry val/rdy output buffer; a bad stop bit pulses
// frame_err, a good frame arriving at a full, non-draining buffer pulses
// overrun and is dropped.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : deserializer side of seq_sreg_8b_deserializer_if (see there)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module seq_sreg_8b_deserializer (
    input  logic                          clk,
    input  logic                          reset,
    seq_sreg_8b_deserializer_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic [7:0]  out_q, out_d;
    logic        val_q, val_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        wr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        out_d   = out_q;
        val_d   = val_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        wr      = 1'b0;

        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (bus.sin) begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                    end
                end
                DATA: begin
                    sr_d  = {sr_q[6:0], bus.sin};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // A bad stop bit returns to IDLE as well; it is never
                    // taken as the start of the next frame.
                    state_d = IDLE;
                    if (bus.sin) begin
                        ferr_d = 1'b1;
                    end else begin
                        wr = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A write into a full buffer succeeds only if the old byte leaves
        // on the same edge; otherwise the new byte is the one dropped.
        if (wr) begin
            if (!val_q || bus.out_rdy) begin
                out_d = sr_q;
                val_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (val_q && bus.out_rdy) begin
            val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            sr_q    <= 8'h00;
            out_q   <= 8'h00;
            val_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            out_q   <= out_d;
            val_q   <= val_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_val   = val_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_seq_sreg_8b_deserializer.sv
module tb_seq_sreg_8b_deserializer;

    logic clk;
    logic reset;

    seq_sreg_8b_deserializer_if bus ();

    seq_sreg_8b_deserializer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // scoreboard state for the random run
    bit         collect  = 0;
    bit         rnd_rdy  = 0;
    bit         wr_flag  = 0;
    logic [7:0] wr_byte  = 8'h00;
    bit         mval     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         exp_ovr  = 0;
    int         got_ovr  = 0;

    // Inputs change at the falling edge; outputs are read at the next one.
    task automatic step(input logic e, input logic s);
        bus.en  = e;
        bus.sin = s;
        if (rnd_rdy) bus.out_rdy = 1'($urandom_range(0, 1));
        if (collect) begin
            if (bus.out_val && bus.out_rdy) got_q.push_back(bus.out);
            if (wr_flag) begin
                if (!mval || bus.out_rdy) begin
                    mval = 1;
                    exp_q.push_back(wr_byte);
                end else begin
                    exp_ovr++;
                end
            end else if (mval && bus.out_rdy) begin
                mval = 0;
            end
        end
        @(negedge clk);
        if (collect && bus.overrun) got_ovr++;
    endtask

    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)));
        step(1'b1, b);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int gap, input bit rdy_stop);
        send_bit(1'b1, gap);
        for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
        for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)));
        if (rdy_stop) bus.out_rdy = 1'b1;
        wr_flag = !stop;
        wr_byte = d;
        step(1'b1, stop);
        wr_flag = 0;
        if (rdy_stop) bus.out_rdy = 1'b0;
    endtask

    task automatic drain();
        bus.out_rdy = 1'b1;
        step(1'b0, 1'b0);
        bus.out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.en = 1'b0; bus.sin = 1'b0; bus.out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.out !== 8'h00) begin n_fail++; $display("FAIL reset_out got=%h want=00", bus.out); end
        n_cmp++;
        if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL reset_val got=%b want=0", bus.out_val); end
        n_cmp++;
        if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses got ferr=%b ovr=%b want 0 0", bus.frame_err, bus.overrun);
        end
        reset = 1'b0;
        step(1'b0, 1'b0);
    endtask

    task automatic test_single();
        send_frame(8'hA5, 1'b0, 0, 0);
        n_cmp++;
        if (bus.out !== 8'hA5 || bus.out_val !== 1'b1) begin
            n_fail++; $display("FAIL single_out got=%h val=%b want=a5 val=1", bus.out, bus.out_val);
        end
        repeat (3) step(1'b0, 1'b0);
        n_cmp++;
        if (bus.out !== 8'hA5 || bus.out_val !== 1'b1) begin
            n_fail++; $display("FAIL single_hold got=%h val=%b want=a5 val=1", bus.out, bus.out_val);
        end
        drain();
        n_cmp++;
        if (bus.out_val !== 1'b0 || bus.out !== 8'hA5) begin
            n_fail++; $display("FAIL single_deq got=%h val=%b want=a5 val=0", bus.out, bus.out_val);
        end
    endtask

    task automatic test_gaps();
        send_frame(8'hA5, 1'b0, 3, 0);
        n_cmp++;
        if (bus.out !== 8'hA5 || bus.out_val !== 1'b1) begin
            n_fail++; $display("FAIL gaps_out got=%h val=%b want=a5 val=1", bus.out, bus.out_val);
        end
        drain();
    endtask

    task automatic test_frame_err();
        send_frame(8'hFF, 1'b1, 0, 0);
        n_cmp++;
        if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_pulse got=%b want=1", bus.frame_err); end
        n_cmp++;
        if (bus.out_val !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++; $display("FAIL ferr_noval got val=%b ovr=%b want 0 0", bus.out_val, bus.overrun);
        end
        step(1'b0, 1'b0);
        n_cmp++;
        if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_width got=%b want=0", bus.frame_err); end
        send_frame(8'h3C, 1'b0, 0, 0);
        n_cmp++;
        if (bus.out !== 8'h3C || bus.out_val !== 1'b1) begin
            n_fail++; $display("FAIL ferr_next got=%h val=%b want=3c val=1", bus.out, bus.out_val);
        end
        drain();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b0, 0, 0);
        send_frame(8'h22, 1'b0, 0, 0);
        n_cmp++;
        if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got=%b want=1", bus.overrun); end
        n_cmp++;
        if (bus.out !== 8'h11 || bus.out_val !== 1'b1) begin
            n_fail++; $display("FAIL ovr_keep got=%h val=%b want=11 val=1", bus.out, bus.out_val);
        end
        step(1'b0, 1'b0);
        n_cmp++;
        if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_width got=%b want=0", bus.overrun); end
        drain();
        // second pass: consumer takes 0x11 on the very edge 0x22 completes
        send_frame(8'h11, 1'b0, 0, 0);
        send_frame(8'h22, 1'b0, 0, 1);
        n_cmp++;
        if (bus.out !== 8'h22 || bus.out_val !== 1'b1) begin
            n_fail++; $display("FAIL simul_out got=%h val=%b want=22 val=1", bus.out, bus.out_val);
        end
        n_cmp++;
        if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL simul_ovr got=%b want=0", bus.overrun); end
    endtask

    task automatic test_reset_mid();
        // buffer still holds 0x22 from the previous scenario
        send_bit(1'b1, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.out !== 8'h00 || bus.out_val !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async got=%h val=%b want=00 val=0", bus.out, bus.out_val);
        end
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 0, 0);
        n_cmp++;
        if (bus.out !== 8'h81 || bus.out_val !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_next got=%h val=%b want=81 val=1", bus.out, bus.out_val);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        mval = 0;
        exp_q.delete();
        got_q.delete();
        exp_ovr = 0;
        got_ovr = 0;
        collect = 1;
        rnd_rdy = 1;
        for (int f = 0; f < 50; f++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b0, $urandom_range(0, 2), 0);
        end
        rnd_rdy = 0;
        bus.out_rdy = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        bus.out_rdy = 1'b0;
        collect = 0;
        n_cmp++;
        if (got_ovr !== exp_ovr) begin n_fail++; $display("FAIL rnd_ovr_count got=%0d want=%0d", got_ovr, exp_ovr); end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rnd_byte_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rnd_byte[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        // full rate with a consumer that is always ready never overruns
        got_ovr = 0;
        collect = 1;
        exp_q.delete();
        got_q.delete();
        bus.out_rdy = 1'b1;
        send_frame(8'h5A, 1'b0, 0, 0);
        send_frame(8'hC3, 1'b0, 0, 0);
        send_frame(8'h0F, 1'b0, 0, 0);
        step(1'b0, 1'b0);
        bus.out_rdy = 1'b0;
        collect = 0;
        n_cmp++;
        if (got_ovr !== 0 || got_q.size() !== 3) begin
            n_fail++; $display("FAIL b2b_rdy got ovr=%0d bytes=%0d want ovr=0 bytes=3", got_ovr, got_q.size());
        end else begin
            n_cmp++;
            if (got_q[0] !== 8'h5A || got_q[1] !== 8'hC3 || got_q[2] !== 8'h0F) begin
                n_fail++; $display("FAIL b2b_bytes got=%h %h %h want=5a c3 0f", got_q[0], got_q[1], got_q[2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gaps();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_sreg_8b_deserializer.md
# seq_sreg_8b_deserializer

Framed serial-in, parallel-out receiver that pairs with the 8-bit serial shift-register transmitter path. It samples one bit per enabled cycle from `sin`, recognizes a start bit, assembles 8 data bits MSB-first (matching the transmitter's MSB-out shift order), checks a stop bit, and presents the byte through a one-entry latency-insensitive val/rdy output buffer. It sits at the receive end of the serial link, between the line and a byte-wide consumer.

## Interface
- Parameters: none (width fixed at 8).
- `clk` input 1 — clock; all state updates on rising edge.
- `reset` input 1 — asynchronous, active-high reset.
- `en` input 1 — bit strobe; `sin` is sampled only on edges where `en`=1.
- `sin` input 1 — serial line; idle level 0.
- `out` output 8 — received byte (buffer contents).
- `out_val` output 1 — buffer holds a valid byte.
- `out_rdy` input 1 — consumer accepts `out` on an edge where `out_val`=1 and `out_rdy`=1.
- `frame_err` output 1 — one-cycle pulse: stop bit was 1.
- `overrun` output 1 — one-cycle pulse: completed frame dropped because buffer was full.

## Operation
- Frame on line (one bit per enabled cycle): start bit 1, data bits d7..d0, stop bit 0. Total 10 enabled cycles.
- FSM states: IDLE, DATA, STOP. 3-bit bit counter, 8-bit shift register `sr`.
- IDLE: on `en`=1 and `sin`=1 → DATA, counter=0. `en`=1, `sin`=0 → stay. `en`=0 → stay.
- DATA: on `en`=1, `sr` ← {sr[6:0], sin}, counter+1; after the 8th data bit (counter was 7) → STOP. `en`=0 holds all state (no timeout).
- STOP: on `en`=1: if `sin`=0, frame good → IDLE, attempt buffer write of `sr`; if `sin`=1 → IDLE, `frame_err` pulses, nothing written, buffer unchanged. A stop bit of 1 is never reinterpreted as a new start bit.
- Buffer write on good frame:
  - buffer empty, or full with `out_rdy`=1 the same cycle → `out` ← `sr`, `out_val`=1.
  - buffer full and `out_rdy`=0 → new byte dropped, `overrun` pulses, old byte retained.
- Dequeue: `out_val`=1 and `out_rdy`=1 with no simultaneous write → `out_val` ← 0; `out` keeps its last value.
- `out_rdy` with `out_val`=0 has no effect.
- `frame_err` and `overrun` are registered pulses, high exactly one cycle, never simultaneously.

## Timing
- Reset (async, immediate): state IDLE, counter 0, `sr`=0, `out`=0x00, `out_val`=0, `frame_err`=0, `overrun`=0. Reset mid-frame aborts the frame; no partial byte appears.
- Latency: `out_val` rises in the cycle after the edge that samples a good stop bit.
- Back-to-back frames: a start bit may be sampled on the enabled cycle right after the stop bit; minimum frame period 10 enabled cycles.
- Consumer holding `out_rdy`=1 permanently: each byte is visible for at least one cycle; never overruns at full line rate.
- All outputs registered; no combinational path from `sin`, `en`, or `out_rdy` to any output.

## Test plan
- Single frame: reset, `out_rdy`=0, `en`=1; drive 1, 1,0,1,0,0,1,0,1, 0 → one cycle after the stop edge `out`=0xA5, `out_val`=1; it stays held while `out_rdy`=0; raising `out_rdy` clears `out_val` next cycle.
- Enable gaps: the same 0xA5 frame with `en`=0 for 3 cycles between every bit, and `sin` toggling during gaps → identical result, 0xA5.
- Framing error: frame 0xFF with stop bit 1 → `frame_err` high for exactly one cycle, `out_val` stays 0, FSM back in IDLE; a following good 0x3C frame yields `out`=0x3C.
- Overrun and simultaneous events: receive 0x11 with `out_rdy`=0, then 0x22 → `overrun` pulses, `out` stays 0x11. Repeat with `out_rdy`=1 exactly on 0x22's completion edge → 0x11 dequeued, `out`=0x22, `out_val`=1, no overrun.
- Reset mid-operation: assert `reset` after 4 data bits, mid-cycle → outputs zero immediately; after release, a full 0x81 frame yields 0x81.
- Random: 50 back-to-back frames with random bytes, random `en` gaps, and random `out_rdy`, checked against a scoreboard of bytes and overrun count.
